// File: rtl/demod_pkg.sv
// demod_pkg: shared state encoding, default settle length and sample extension helper.
package demod_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, RUN} arb_state_e;
  localparam int DEF_SETTLE_CYC = 64;
  localparam int MAX_W = 64;
  function automatic logic [MAX_W-1:0] sext_or_zext(input logic [MAX_W-1:0] sample, input int in_w, input logic signed_flag);
    logic [MAX_W-1:0] r;
    r = sample << (MAX_W - in_w);
    return signed_flag ? $unsigned($signed(r) >>> (MAX_W - in_w)) : r >> (MAX_W - in_w);
  endfunction
endpackage

// File: rtl/demod_settle_timer.sv
// demod_settle_timer: loadable down-counter, done while the count sits at zero.
module demod_settle_timer #(
  parameter int CYC = 64
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic load,
  input  logic en,
  output logic done
);
  localparam int W = $clog2(CYC + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) cnt <= '0;
    else if (load) cnt <= W'(CYC - 1);
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign done = cnt == '0;
endmodule

// File: rtl/demod_output_arbiter.sv
// demod_output_arbiter: N_CH-way demod output selector with settle blanking.
// Define DEMOD_ARB_HOLD_EN to keep the last RUN sample on d_out in IDLE/SETTLE.
module demod_output_arbiter
  import demod_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int IN_W = 16,
  parameter int OUT_W = 16,
  parameter logic [N_CH-1:0] SIGNED_MASK = 4'b0110,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [N_CH*IN_W-1:0] ch_data,
  input  logic [N_CH-1:0]      ch_valid,
  input  logic [SEL_W-1:0]     mode_select,
  input  logic                 run_en,
  output logic [OUT_W-1:0]     d_out,
  output logic                 d_valid,
  output logic [SEL_W-1:0]     active_mode,
  output logic                 switching,
  output logic [N_CH-1:0]      mode_onehot
);
`ifdef DEMOD_ARB_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  arb_state_e st, st_n;
  logic sel_ok, load, done, accept;
  always_comb begin
    st_n = st;
    load = 1'b0;
    sel_ok = run_en && 32'(mode_select) < N_CH;
    if (!sel_ok) st_n = IDLE;
    else if (st == IDLE || mode_select != active_mode) begin
      st_n = SETTLE;
      load = 1'b1;
    end else if (st == SETTLE && done) st_n = RUN;
    accept = st == RUN && st_n == RUN && ch_valid[active_mode];
  end
  demod_settle_timer #(.CYC(SETTLE_CYC)) u_timer (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .load(load),
    .en(st == SETTLE),
    .done(done)
  );
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      st <= IDLE;
      active_mode <= '0;
      d_out <= '0;
      d_valid <= 1'b0;
    end else begin
      st <= st_n;
      d_valid <= accept;
      if (load) active_mode <= mode_select;
      if (accept) d_out <= OUT_W'(sext_or_zext(MAX_W'(ch_data[active_mode*IN_W +: IN_W]), IN_W, SIGNED_MASK[active_mode]));
      else if (!HOLD && st_n != RUN) d_out <= '0;
    end
  end
  assign switching = st == SETTLE;
  assign mode_onehot = st == RUN ? N_CH'(1) << active_mode : '0;
endmodule

// File: tb/tb_demod_output_arbiter.sv
// tb_demod_output_arbiter: directed and random checks against a cycle-level reference model.
module tb_demod_output_arbiter;
`ifdef DEMOD_ARB_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  localparam int NC = 4;
  localparam int SC = 64;
  localparam logic [3:0] MASK = 4'b0110;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic [7:0] ch_d [NC];
  logic [31:0] ch_data;
  logic [3:0] ch_valid = '0;
  logic [1:0] mode_select = '0;
  logic run_en = 1'b0;
  logic [15:0] d_out;
  logic d_valid;
  logic [1:0] active_mode;
  logic switching;
  logic [3:0] mode_onehot;
  int n_chk = 0, n_err = 0;
  bit m_run;
  int m_win, m_act;
  logic [15:0] m_out;
  bit m_v;
  assign ch_data = {ch_d[3], ch_d[2], ch_d[1], ch_d[0]};
  always #5 sys_clk = ~sys_clk;
  demod_output_arbiter #(.N_CH(NC), .IN_W(8), .OUT_W(16), .SIGNED_MASK(MASK), .SETTLE_CYC(SC)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ch_data(ch_data), .ch_valid(ch_valid),
    .mode_select(mode_select), .run_en(run_en), .d_out(d_out), .d_valid(d_valid),
    .active_mode(active_mode), .switching(switching), .mode_onehot(mode_onehot)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    logic rn, en;
    int sel;
    logic [3:0] v;
    logic [7:0] s [NC];
    rn = sys_rst_n; en = run_en; sel = int'(mode_select); v = ch_valid; s = ch_d;
    @(posedge sys_clk);
    #1;
    if (!rn) begin
      m_run = 0; m_win = 0; m_act = 0; m_out = '0; m_v = 0;
    end else if (!en || sel >= NC) begin
      m_run = 0; m_win = 0; m_v = 0;
      if (!HOLD) m_out = '0;
    end else if ((!m_run && m_win == 0) || sel != m_act) begin
      m_act = sel; m_win = SC; m_run = 0; m_v = 0;
      if (!HOLD) m_out = '0;
    end else if (m_win > 0) begin
      m_win--; m_v = 0;
      if (m_win == 0) m_run = 1;
    end else begin
      m_v = v[m_act];
      if (m_v) m_out = MASK[m_act] ? 16'($signed(s[m_act])) : 16'(s[m_act]);
    end
    chk("d_valid", 32'(d_valid), 32'(m_v));
    chk("d_out", 32'(d_out), 32'(m_out));
    chk("switching", 32'(switching), 32'(m_win > 0));
    chk("active_mode", 32'(active_mode), 32'(m_act));
    chk("mode_onehot", 32'(mode_onehot), m_run ? 32'(1) << m_act : 32'(0));
  endtask
  task automatic wait_run();
    for (int i = 0; i < 4 * SC && mode_onehot == '0; i++) tick();
    chk("reach_run", 32'(mode_onehot != '0), 32'(1));
  endtask
  initial begin
    int cnt;
    for (int i = 0; i < NC; i++) ch_d[i] = '0;
    tick();
    tick();
    sys_rst_n = 1'b1;
    run_en = 1'b1;
    mode_select = 2'd1;
    tick();
    cnt = 0;
    for (int i = 0; i < 4 * SC && switching; i++) begin
      cnt++;
      tick();
    end
    chk("settle_len", 32'(cnt), 32'(SC));
    ch_d[1] = 8'hF0; ch_valid = 4'b0010;
    tick();
    chk("ch1_sext", 32'(d_out), 32'hFFF0);
    ch_valid = 4'hF;
    sys_rst_n = 1'b0;
    tick();
    chk("rst_dout", 32'(d_out), 32'h0);
    chk("rst_onehot", 32'(mode_onehot), 32'h0);
    sys_rst_n = 1'b1; ch_valid = '0; mode_select = 2'd0;
    tick();
    wait_run();
    ch_d[0] = 8'hF0; ch_d[2] = 8'h55; ch_valid = 4'b0101;
    tick();
    chk("ch0_zext", 32'(d_out), 32'h00F0);
    ch_valid = 4'b0100;
    tick();
    chk("ch2_ignored", 32'(d_valid), 32'h0);
    ch_valid = '0; mode_select = 2'd1;
    wait_run();
    mode_select = 2'd2;
    for (int i = 0; i < 10; i++) tick();
    mode_select = 2'd3;
    tick();
    cnt = 0;
    for (int i = 0; i < 4 * SC && switching; i++) begin
      cnt++;
      tick();
    end
    chk("restart_len", 32'(cnt), 32'(SC));
    chk("restart_mode", 32'(active_mode), 32'd3);
    ch_valid = 4'hF; run_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("off_no_valid", 32'(d_valid), 32'h0);
    ch_valid = '0; run_en = 1'b1; mode_select = 2'd0;
    tick();
    wait_run();
    ch_d[0] = 8'h34; ch_valid = 4'b0001;
    tick();
    ch_valid = '0; mode_select = 2'd1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("hold", 32'(d_out), HOLD ? 32'h34 : 32'h0);
    end
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NC; c++) ch_d[c] = 8'($urandom);
      ch_valid = 4'($urandom);
      run_en = $urandom_range(0, 99) != 0;
      if ($urandom_range(0, 199) == 0) mode_select = 2'($urandom);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
